// File: rtl/fsm_trial_monitor.sv
// rtl/fsm_trial_monitor.sv - trial sequencer and target-hit monitor for the two-bit state machine
// Runs fixed-length trials, records first-hit latency and reports one result per trial.
module fsm_trial_monitor #(
   parameter int unsigned TRIAL_LEN = 100,
   parameter logic [1:0]  TARGET    = 2'b11,
   parameter int unsigned LAT_W     = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             A,
   input  logic [1:0]       STATE,
   output logic             TRIAL_START,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic             RES_HIT,
   output logic [LAT_W-1:0] RES_LAT,
   output logic             RES_A,
   output logic [CNT_W-1:0] TRIAL_CNT,
   output logic [CNT_W-1:0] HIT_CNT,
   output logic             OVERFLOW
);

   localparam int unsigned      CYC_W    = (TRIAL_LEN > 1) ? $clog2(TRIAL_LEN) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TRIAL_LEN - 1);
   localparam logic [LAT_W-1:0] LAT_ONES = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             hit_q, hit_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             a_cap_q, a_cap_d;
   logic [CNT_W-1:0] trial_cnt_q, trial_cnt_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic             res_valid_q, res_valid_d;
   logic             res_hit_q, res_hit_d;
   logic [LAT_W-1:0] res_lat_q, res_lat_d;
   logic             res_a_q, res_a_d;
   logic             overflow_q, overflow_d;
   logic             trial_start;

   // Latency clamps at the field maximum when the run index no longer fits.
   logic [31:0]      cyc_ext;
   logic [LAT_W-1:0] lat_now;
   assign cyc_ext = 32'(cyc_q);
   assign lat_now = (cyc_ext > 32'(LAT_ONES)) ? LAT_ONES : LAT_W'(cyc_q);

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      hit_d       = hit_q;
      lat_d       = lat_q;
      a_cap_d     = a_cap_q;
      trial_cnt_d = trial_cnt_q;
      hit_cnt_d   = hit_cnt_q;
      res_valid_d = res_valid_q;
      res_hit_d   = res_hit_q;
      res_lat_d   = res_lat_q;
      res_a_d     = res_a_q;
      overflow_d  = overflow_q;
      trial_start = 1'b0;

      if (res_valid_q && RES_READY) begin
         res_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (EN) begin
               state_d = S_START;
            end
         end
         S_START: begin
            trial_start = 1'b1;
            a_cap_d     = A;
            cyc_d       = '0;
            hit_d       = 1'b0;
            lat_d       = '0;
            state_d     = S_RUN;
         end
         S_RUN: begin
            if ((STATE == TARGET) && !hit_q) begin
               hit_d = 1'b1;
               lat_d = lat_now;
            end
            if (cyc_q == CYC_LAST) begin
               state_d = S_DONE;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_DONE: begin
            if (trial_cnt_q != '1) begin
               trial_cnt_d = trial_cnt_q + 1'b1;
            end
            if (hit_q && (hit_cnt_q != '1)) begin
               hit_cnt_d = hit_cnt_q + 1'b1;
            end
            // A result being accepted on this edge frees the slot for the new one.
            if (!res_valid_q || RES_READY) begin
               res_valid_d = 1'b1;
               res_hit_d   = hit_q;
               res_lat_d   = lat_q;
               res_a_d     = a_cap_q;
            end else begin
               overflow_d = 1'b1;
            end
            state_d = EN ? S_START : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         hit_q       <= 1'b0;
         lat_q       <= '0;
         a_cap_q     <= 1'b0;
         trial_cnt_q <= '0;
         hit_cnt_q   <= '0;
         res_valid_q <= 1'b0;
         res_hit_q   <= 1'b0;
         res_lat_q   <= '0;
         res_a_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         hit_q       <= hit_d;
         lat_q       <= lat_d;
         a_cap_q     <= a_cap_d;
         trial_cnt_q <= trial_cnt_d;
         hit_cnt_q   <= hit_cnt_d;
         res_valid_q <= res_valid_d;
         res_hit_q   <= res_hit_d;
         res_lat_q   <= res_lat_d;
         res_a_q     <= res_a_d;
         overflow_q  <= overflow_d;
      end
   end

   assign TRIAL_START = trial_start;
   assign RES_VALID   = res_valid_q;
   assign RES_HIT     = res_hit_q;
   assign RES_LAT     = res_lat_q;
   assign RES_A       = res_a_q;
   assign TRIAL_CNT   = trial_cnt_q;
   assign HIT_CNT     = hit_cnt_q;
   assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_fsm_trial_monitor.sv
// tb/tb_fsm_trial_monitor.sv - scoreboard bench for fsm_trial_monitor
module tb_fsm_trial_monitor;
   localparam int TL = 8;
   localparam int LW = 8;
   localparam int CW = 16;

   typedef logic [LW+1:0] res_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          EN = 1'b0;
   logic          A = 1'b0;
   logic [1:0]    STATE = 2'b00;
   logic          RES_READY = 1'b0;
   logic          TRIAL_START;
   logic          RES_VALID;
   logic          RES_HIT;
   logic [LW-1:0] RES_LAT;
   logic          RES_A;
   logic [CW-1:0] TRIAL_CNT;
   logic [CW-1:0] HIT_CNT;
   logic          OVERFLOW;

   fsm_trial_monitor #(
      .TRIAL_LEN(TL),
      .TARGET   (2'b11),
      .LAT_W    (LW),
      .CNT_W    (CW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .EN         (EN),
      .A          (A),
      .STATE      (STATE),
      .TRIAL_START(TRIAL_START),
      .RES_VALID  (RES_VALID),
      .RES_READY  (RES_READY),
      .RES_HIT    (RES_HIT),
      .RES_LAT    (RES_LAT),
      .RES_A      (RES_A),
      .TRIAL_CNT  (TRIAL_CNT),
      .HIT_CNT    (HIT_CNT),
      .OVERFLOW   (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc_cnt = 0;
   int   ts_pulses = 0;
   int   last_start = 0;
   res_t exp_q[$];
   res_t cur_p;
   res_t prev_p = '0;
   res_t exp_p;
   logic prev_v = 1'b0;
   logic prev_r = 1'b0;

   always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks payload hold under back-pressure.
   always @(negedge CLK) begin
      cur_p = {RES_HIT, RES_LAT, RES_A};
      if (TRIAL_START === 1'b1) ts_pulses++;
      if (prev_v && !prev_r && (RES_VALID === 1'b1)) check("payload_hold", 32'(cur_p), 32'(prev_p));
      if ((RES_VALID === 1'b1) && RES_READY) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got %0h with empty scoreboard at %0t", cur_p, $time);
         end else begin
            exp_p = exp_q.pop_front();
            check("result", 32'(cur_p), 32'(exp_p));
         end
      end
      prev_v = (RES_VALID === 1'b1);
      prev_r = RES_READY;
      prev_p = cur_p;
   end

   task automatic wait_start(input bit chk_period);
      int n = 0;
      while ((TRIAL_START !== 1'b1) && (n < 50)) begin
         @(posedge CLK); #1;
         n++;
      end
      if (TRIAL_START !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL start_timeout: TRIAL_START=%b, required 1 within 50 cycles", TRIAL_START);
      end else if (chk_period) begin
         check("start_period", 32'(cyc_cnt - last_start), 32'(TL + 2));
      end
      last_start = cyc_cnt;
   endtask

   task automatic run_trial(input logic a, input logic [TL-1:0] mask, input logic rdy_run,
                            input logic rdy_done, input bit en_drop, input bit push,
                            input logic exp_hit, input logic [LW-1:0] exp_lat, input bit chk_period);
      wait_start(chk_period);
      A = a;
      for (int c = 0; c < TL; c++) begin
         @(posedge CLK); #1;
         if (c == 0) RES_READY = rdy_run;
         if ((c == 4) && en_drop) EN = 1'b0;
         STATE = mask[c] ? 2'b11 : 2'b00;
      end
      @(posedge CLK); #1;
      STATE = 2'b00;
      RES_READY = rdy_done;
      if (push) exp_q.push_back({exp_hit, exp_lat, a});
      @(posedge CLK); #1;
   endtask

   task automatic do_reset();
      EN = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   int ts_mark;

   initial begin
      // Reset and idle
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      repeat (20) @(posedge CLK);
      #1;
      check("idle_trial_start_pulses", 32'(ts_pulses), 32'd0);
      check("idle_valid", 32'(RES_VALID), 32'd0);
      check("idle_payload", 32'({RES_HIT, RES_LAT, RES_A}), 32'd0);
      check("idle_trial_cnt", 32'(TRIAL_CNT), 32'd0);
      check("idle_hit_cnt", 32'(HIT_CNT), 32'd0);
      check("idle_overflow", 32'(OVERFLOW), 32'd0);

      // Hit at cycles 3 and 5, then a miss and a last-cycle hit
      RES_READY = 1'b1;
      EN = 1'b1;
      run_trial(1'b1, 8'b0010_1000, 1'b1, 1'b1, 0, 1, 1'b1, 8'd3, 0);
      check("hit_trial_cnt", 32'(TRIAL_CNT), 32'd1);
      check("hit_hit_cnt", 32'(HIT_CNT), 32'd1);
      run_trial(1'b0, 8'b0000_0000, 1'b1, 1'b1, 0, 1, 1'b0, 8'd0, 1);
      check("miss_trial_cnt", 32'(TRIAL_CNT), 32'd2);
      check("miss_hit_cnt", 32'(HIT_CNT), 32'd1);
      run_trial(1'b1, 8'b1000_0000, 1'b1, 1'b1, 0, 1, 1'b1, 8'd7, 1);
      check("last_trial_cnt", 32'(TRIAL_CNT), 32'd3);
      check("last_hit_cnt", 32'(HIT_CNT), 32'd2);
      check("last_overflow", 32'(OVERFLOW), 32'd0);

      // Back-pressure: second result dropped while the first is held
      do_reset();
      EN = 1'b1;
      run_trial(1'b1, 8'b0000_0100, 1'b0, 1'b0, 0, 1, 1'b1, 8'd2, 0);
      run_trial(1'b0, 8'b0000_0000, 1'b0, 1'b0, 1, 0, 1'b0, 8'd0, 1);
      check("bp_overflow", 32'(OVERFLOW), 32'd1);
      check("bp_trial_cnt", 32'(TRIAL_CNT), 32'd2);
      check("bp_hit_cnt", 32'(HIT_CNT), 32'd1);
      check("bp_valid", 32'(RES_VALID), 32'd1);
      check("bp_payload", 32'({RES_HIT, RES_LAT, RES_A}), 32'({1'b1, 8'd2, 1'b1}));
      RES_READY = 1'b1;
      @(posedge CLK); #1;
      RES_READY = 1'b0;
      check("bp_valid_fall", 32'(RES_VALID), 32'd0);
      check("bp_overflow_sticky", 32'(OVERFLOW), 32'd1);
      EN = 1'b1;
      run_trial(1'b0, 8'b0100_0000, 1'b0, 1'b0, 0, 1, 1'b1, 8'd6, 0);
      run_trial(1'b1, 8'b0000_0001, 1'b0, 1'b1, 0, 1, 1'b1, 8'd0, 1);
      check("accept_load_valid", 32'(RES_VALID), 32'd1);
      check("accept_load_trial_cnt", 32'(TRIAL_CNT), 32'd4);
      check("accept_load_hit_cnt", 32'(HIT_CNT), 32'd3);

      // EN drop mid-trial: trial completes, then idle
      run_trial(1'b1, 8'b0000_0000, 1'b1, 1'b1, 1, 1, 1'b0, 8'd0, 1);
      check("endrop_trial_cnt", 32'(TRIAL_CNT), 32'd5);
      check("endrop_hit_cnt", 32'(HIT_CNT), 32'd3);
      ts_mark = ts_pulses;
      repeat (20) @(posedge CLK);
      #1;
      check("endrop_no_start", 32'(ts_pulses), 32'(ts_mark));
      check("endrop_valid", 32'(RES_VALID), 32'd0);

      // Reset mid-run
      EN = 1'b1;
      wait_start(0);
      A = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         @(posedge CLK); #1;
         STATE = (c == 2) ? 2'b11 : 2'b00;
         if (c == 4) RST = 1'b1;
      end
      @(posedge CLK); #1;
      check("rst_trial_start", 32'(TRIAL_START), 32'd0);
      check("rst_valid", 32'(RES_VALID), 32'd0);
      check("rst_payload", 32'({RES_HIT, RES_LAT, RES_A}), 32'd0);
      check("rst_trial_cnt", 32'(TRIAL_CNT), 32'd0);
      check("rst_hit_cnt", 32'(HIT_CNT), 32'd0);
      check("rst_overflow", 32'(OVERFLOW), 32'd0);
      RST = 1'b0;
      STATE = 2'b00;
      @(posedge CLK); #1;
      check("rst_restart", 32'(TRIAL_START), 32'd1);
      run_trial(1'b0, 8'b0000_0000, 1'b1, 1'b1, 1, 1, 1'b0, 8'd0, 0);
      check("post_rst_trial_cnt", 32'(TRIAL_CNT), 32'd1);
      check("post_rst_hit_cnt", 32'(HIT_CNT), 32'd0);

      repeat (5) @(posedge CLK);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
